// File: rtl/div_seq_pkg.sv
// Shared encodings and default sizing for the divider sequencer.
package div_seq_pkg;

  localparam int ITERATIONS_DEF = 24;
  localparam int CNT_W_DEF      = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter: synchronous clear, increment, and terminal-count flag.
module div_iter_counter #(
  parameter int CNT_W      = 5,
  parameter int ITERATIONS = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == CNT_W'(ITERATIONS - 1));

endmodule

// File: rtl/div_sequencer.sv
// Control FSM for the iterative mantissa divider (IDLE -> INIT -> ITER -> DONE).
// Optional early termination on a zero remainder: define DIV_SEQ_EARLY_TERM_EN.
module div_sequencer
  import div_seq_pkg::*;
#(
  parameter int ITERATIONS = ITERATIONS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_by_zero,
  input  logic             rem_zero,
  output logic             init_load,
  output logic             step_en,
  output logic [CNT_W-1:0] iter_count,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dbz_flag
);

  state_t state_reg;
  state_t state_next;
  logic   dbz_reg;
  logic   dbz_set;
  logic   dbz_clr;
  logic   cnt_clear;
  logic   cnt_inc;
  logic   cnt_last;
  logic   early_stop;

`ifdef DIV_SEQ_EARLY_TERM_EN
  assign early_stop = rem_zero;
`else
  logic rem_zero_unused;
  assign rem_zero_unused = rem_zero;
  assign early_stop      = 1'b0;
`endif

  div_iter_counter #(
    .CNT_W      (CNT_W),
    .ITERATIONS (ITERATIONS)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (iter_count),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (dbz_set) begin
        dbz_reg <= 1'b1;
      end else if (dbz_clr) begin
        dbz_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    dbz_set    = 1'b0;
    dbz_clr    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          if (div_by_zero) begin
            state_next = S_DONE;
            dbz_set    = 1'b1;
          end else begin
            state_next = S_INIT;
          end
        end
      end
      S_INIT: begin
        state_next = S_ITER;
        cnt_clear  = 1'b1;
      end
      S_ITER: begin
        // The count freezes on the final step so it records steps taken minus one.
        if (cnt_last || early_stop) begin
          state_next = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
          cnt_clear  = 1'b1;
          dbz_clr    = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign init_load = (state_reg == S_INIT);
  assign step_en   = (state_reg == S_ITER);
  assign busy      = (state_reg == S_INIT) || (state_reg == S_ITER);
  assign out_valid = (state_reg == S_DONE);
  assign dbz_flag  = dbz_reg;

endmodule
